// File: rtl/low_priority_request_arbiter.sv
// Fixed low-index-priority arbiter with a per-grant hold limit.
// Ports: Clk_In, Reset_In (async high), Enable_In, Req_In in;
//        Grant_Out, Grant_Valid_Out, Grant_Index_Out, Timeout_Out out.
module low_priority_request_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 15,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               Clk_In,
  input  logic               Reset_In,
  input  logic               Enable_In,
  input  logic [NUM_REQ-1:0] Req_In,
  output logic [NUM_REQ-1:0] Grant_Out,
  output logic               Grant_Valid_Out,
  output logic [IW-1:0]      Grant_Index_Out,
  output logic               Timeout_Out
);

  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_TOP =
    (MAX_HOLD > 0) ? HOLD_MAX : {CW{1'b1}};
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               valid_q, valid_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic               tout_q, tout_d;

  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] eff;
  logic [IW-1:0]      win;

  // A masked requester is still served when it is the only one asking.
  always_comb begin
    masked = Req_In & ~mask_q;
    eff    = (|masked) ? masked : Req_In;
    win    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eff[i]) win = IW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    tout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        idx_d   = '0;
        cnt_d   = '0;
        if (Enable_In && (|eff)) begin
          state_d = GRANT;
          grant_d = ONE << win;
          idx_d   = win;
          cnt_d   = CW'(1);
          // The mask has served its purpose once anyone is granted.
          mask_d  = '0;
        end else if (|(mask_q & ~Req_In)) begin
          mask_d = '0;
        end
      end
      GRANT: begin
        if (!Req_In[idx_q]) begin
          state_d = IDLE;
          grant_d = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if ((MAX_HOLD != 0) && (cnt_q == HOLD_MAX)) begin
          state_d = IDLE;
          grant_d = '0;
          idx_d   = '0;
          cnt_d   = '0;
          mask_d  = grant_q;
          tout_d  = 1'b1;
        end else if (cnt_q != CNT_TOP) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = |grant_d;
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      tout_q  <= tout_d;
    end
  end

  assign Grant_Out       = grant_q;
  assign Grant_Valid_Out = valid_q;
  assign Grant_Index_Out = idx_q;
  assign Timeout_Out     = tout_q;

endmodule

// File: tb/tb_low_priority_request_arbiter.sv
// Scoreboard bench for low_priority_request_arbiter.
// Reference model tracks owner/hold/blocked requester as integers.
module tb_low_priority_request_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 15;

  logic         clk;
  logic         rst;
  logic         en;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gv;
  logic [1:0]   gix;
  logic         tout;

  low_priority_request_arbiter #(
    .NUM_REQ (N),
    .MAX_HOLD(MAXH)
  ) dut (
    .Clk_In         (clk),
    .Reset_In       (rst),
    .Enable_In      (en),
    .Req_In         (req),
    .Grant_Out      (gnt),
    .Grant_Valid_Out(gv),
    .Grant_Index_Out(gix),
    .Timeout_Out    (tout)
  );

  typedef struct {
    logic [N-1:0] g;
    logic         v;
    logic [1:0]   ix;
    logic         t;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // model state
  int owner   = -1;
  int held    = 0;
  int blocked = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    owner   = -1;
    held    = 0;
    blocked = -1;
  endtask

  // Advance the model by one edge with inputs r/e and queue the result.
  task automatic model_edge(input logic [N-1:0] r, input logic e);
    exp_t x;
    int   pick;
    bit   fired;
    fired = 0;
    if (owner < 0) begin
      pick = -1;
      for (int i = 0; i < N; i++)
        if (pick < 0 && r[i] && i != blocked) pick = i;
      if (pick < 0)
        for (int i = 0; i < N; i++)
          if (pick < 0 && r[i]) pick = i;
      if (e && pick >= 0) begin
        owner   = pick;
        held    = 1;
        blocked = -1;
      end else if (blocked >= 0 && !r[blocked]) begin
        blocked = -1;
      end
    end else if (!r[owner]) begin
      owner = -1;
    end else if (held == MAXH) begin
      blocked = owner;
      owner   = -1;
      fired   = 1;
    end else begin
      held++;
    end
    x.g  = '0;
    x.v  = 1'b0;
    x.ix = '0;
    x.t  = fired;
    if (owner >= 0) begin
      x.g[owner] = 1'b1;
      x.v        = 1'b1;
      x.ix       = 2'(owner);
    end
    exp_q.push_back(x);
  endtask

  task automatic step(input logic [N-1:0] r, input logic e);
    @(negedge clk);
    req = r;
    en  = e;
    model_edge(r, e);
  endtask

  task automatic check_zero(input string name);
    total++;
    if (gnt !== '0 || gv !== 1'b0 || gix !== '0 || tout !== 1'b0) begin
      bad++;
      $display("FAIL %s: got g=%b v=%b ix=%0d t=%b want all 0",
               name, gnt, gv, gix, tout);
    end
  endtask

  // Monitor: compare every post-edge output against the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (gnt !== e.g || gv !== e.v || gix !== e.ix || tout !== e.t) begin
        bad++;
        $display("FAIL out @%0t: got g=%b v=%b ix=%0d t=%b want g=%b v=%b ix=%0d t=%b",
                 $time, gnt, gv, gix, tout, e.g, e.v, e.ix, e.t);
      end
      total++;
      if ($countones(gnt) > 1 || gv !== (|gnt)) begin
        bad++;
        $display("FAIL onehot @%0t: got g=%b v=%b want one-hot, v=|g",
                 $time, gnt, gv);
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    logic         e;
    rst = 1'b1;
    en  = 1'b0;
    req = '0;
    model_reset();
    #12;
    check_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step(4'b0000, 1'b1);

    // priority, release, bubble
    step(4'b1010, 1'b1);
    step(4'b1010, 1'b1);
    step(4'b1000, 1'b1);
    repeat (3) step(4'b1000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // timeout and fairness
    repeat (20) step(4'b0011, 1'b1);
    repeat (2) step(4'b0000, 1'b1);

    // masked-only requester
    repeat (16) step(4'b0011, 1'b1);
    repeat (4) step(4'b0001, 1'b1);
    repeat (2) step(4'b0000, 1'b1);

    // drop on the timeout edge
    repeat (15) step(4'b0101, 1'b1);
    repeat (3) step(4'b0100, 1'b1);
    repeat (2) step(4'b0000, 1'b1);

    // enable gating
    repeat (3) step(4'b1111, 1'b0);
    step(4'b0010, 1'b1);
    repeat (5) step(4'b0010, 1'b0);
    repeat (2) step(4'b0000, 1'b0);

    // asynchronous reset mid-grant
    repeat (3) step(4'b0100, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step(4'b0000, 1'b1);

    // random sticky requests so long holds and timeouts occur
    r = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      e = ($urandom_range(7) != 0);
      step(r, e);
    end

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
